// File: rtl/onehot_monitor.sv
// Two-stage one-hot checker/encoder: popcount, lowest-set-bit index, per-result
// violation flag, and saturating violation accounting with first-violation capture.
module onehot_monitor #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter int POP_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic             clr,
  output logic             out_valid,
  output logic             out_onehot,
  output logic             out_onehot0,
  output logic [POP_W-1:0] out_popcnt,
  output logic [IDX_W-1:0] out_index,
  output logic             out_viol,
  output logic             viol_sticky,
  output logic [CNT_W-1:0] viol_count,
  output logic [WIDTH-1:0] first_viol_data,
  output logic             first_viol_mode
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [POP_W-1:0] POP_ONE = POP_W'(1);

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_data_r;
  logic             s1_mode_r;
  logic             captured_r;

  logic [POP_W-1:0] pop_s;
  logic [IDX_W-1:0] idx_s;
  logic             viol_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_W'(1);
  endfunction

  // Stage 1: unconditional capture of the qualified input beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_mode_r  <= 1'b0;
    end else begin
      s1_valid_r <= in_valid;
      s1_data_r  <= in_data;
      s1_mode_r  <= in_mode;
    end
  end

  // Popcount and lowest-set-bit index of the stage-1 vector; scanning downward
  // lets the lowest set bit win the final assignment.
  always_comb begin
    pop_s = '0;
    idx_s = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      pop_s = pop_s + POP_W'(s1_data_r[i]);
      idx_s = s1_data_r[i] ? IDX_W'(i) : idx_s;
    end
    viol_s = s1_mode_r ? (pop_s > POP_ONE) : (pop_s != POP_ONE);
  end

  // Stage 2: result fields hold between valid beats; out_viol is qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_onehot  <= 1'b0;
      out_onehot0 <= 1'b0;
      out_popcnt  <= '0;
      out_index   <= '0;
      out_viol    <= 1'b0;
    end else begin
      out_valid <= s1_valid_r;
      out_viol  <= s1_valid_r & viol_s;
      if (s1_valid_r) begin
        out_onehot  <= (pop_s == POP_ONE);
        out_onehot0 <= (pop_s <= POP_ONE);
        out_popcnt  <= pop_s;
        out_index   <= idx_s;
      end else begin
        out_onehot  <= out_onehot;
        out_onehot0 <= out_onehot0;
        out_popcnt  <= out_popcnt;
        out_index   <= out_index;
      end
    end
  end

  // Violation accounting; clr takes priority over a violation landing the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_sticky     <= 1'b0;
      viol_count      <= '0;
      first_viol_data <= '0;
      first_viol_mode <= 1'b0;
      captured_r      <= 1'b0;
    end else if (clr) begin
      viol_sticky     <= 1'b0;
      viol_count      <= '0;
      first_viol_data <= '0;
      first_viol_mode <= 1'b0;
      captured_r      <= 1'b0;
    end else if (s1_valid_r && viol_s) begin
      viol_sticky <= 1'b1;
      viol_count  <= sat_inc(viol_count);
      if (!captured_r) begin
        first_viol_data <= s1_data_r;
        first_viol_mode <= s1_mode_r;
        captured_r      <= 1'b1;
      end else begin
        first_viol_data <= first_viol_data;
        first_viol_mode <= first_viol_mode;
        captured_r      <= captured_r;
      end
    end else begin
      viol_sticky <= viol_sticky;
      viol_count  <= viol_count;
    end
  end

endmodule

// File: doc/onehot_monitor.md
Name: onehot_monitor

Overview:
- Pipelined, parametrised one-hot checker and encoder for a WIDTH-bit vector.
- Successor to combinational $onehot checks: adds onehot/onehot0 runtime mode, popcount, hot-bit index encoding, and saturating violation counting with first-violation capture.
- Sits on a qualified data path (arbiter grants, mux selects, FSM state vectors) as an always-on monitor; results feed a status/debug block.

Parameters:
- WIDTH, 128, width of checked vector; legal range 1..1024.
- CNT_W, 8, width of saturating violation counter; legal range 1..32.
- IDX_W, $clog2(WIDTH) (minimum 1), width of encoded index (derived; not overridden).
- POP_W, $clog2(WIDTH+1), width of popcount (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data and in_mode qualified this cycle.
- in_data  input  WIDTH  vector to check.
- in_mode  input  1  0 = exactly one bit required (onehot); 1 = at most one bit allowed (onehot0).
- clr  input  1  synchronous clear of sticky/count/capture state.
- out_valid  output  1  result valid, two cycles after in_valid.
- out_onehot  output  1  popcount == 1.
- out_onehot0  output  1  popcount <= 1.
- out_popcnt  output  POP_W  number of set bits.
- out_index  output  IDX_W  index of lowest set bit; 0 when popcount == 0.
- out_viol  output  1  violation for this result under its sampled mode.
- viol_sticky  output  1  set by any violation since reset/clr.
- viol_count  output  CNT_W  saturating violation count.
- first_viol_data  output  WIDTH  in_data of first violation since reset/clr.
- first_viol_mode  output  1  mode of first violation.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and pipeline registers go to 0 immediately and stay 0 while rst_n is low.
- Stage 1 (cycle N+1): register in_valid, in_data and in_mode. The register is always loaded; data is don't-care when valid = 0.
- Stage 2 (cycle N+2):
  - Compute popcount and lowest-set-bit index from stage-1 data.
  - Register all out_* results.
  - out_valid = stage-1 valid.
- Latency is fixed at 2 cycles; throughput is 1 per cycle with no backpressure.
- Out_* fields when out_valid = 0: hold their last values; they are not zeroed.
- Violation:
  - out_viol = out_valid & (mode ? popcnt > 1 : popcnt != 1).
  - Mode is the value sampled with that data, so a mode change affects only subsequently captured data.
- Accounting (updated on the cycle a stage-2 result with a violation is registered):
  - viol_sticky <= 1.
  - viol_count increments and saturates at 2^CNT_W - 1 (no wrap).
  - If first_viol not yet captured, first_viol_data/mode load and an internal captured flag sets.
- clr:
  - Synchronous; clears viol_sticky, viol_count, first_viol_data, first_viol_mode and the captured flag on the next edge.
  - Does not flush or affect the pipeline or out_* result fields.
  - clr coincident with a violation arriving at stage 2: clr wins; that violation is neither counted nor captured. out_viol still reports it.
- Reset mid-operation: in-flight data is discarded; the first out_valid after reset release is 2 cycles after the first post-reset in_valid.
- Edge cases:
  - WIDTH = 1: IDX_W = 1, out_index always 0.
  - All-zero data in mode 0 is a violation; all-zero data in mode 1 is not.
- X/Z in in_data: behaviour unspecified; the bench drives 2-state values only.

Test Plan:
- Reset and basic latency:
  - Stimulus: rst_n low then release; in_valid = 1, in_data = 128'h1 << 77, mode 0 at cycle 0.
  - Response: cycle 2 gives out_valid = 1, out_onehot = 1, out_index = 77, out_popcnt = 1, out_viol = 0.
  - All outputs are 0 during reset.
- Mode semantics:
  - Stimulus: data = 0, first with mode 0, then with mode 1.
  - Response: viol = 1 then viol = 0; onehot0 = 1 for both; out_index = 0.
  - Also: data = 128'h5 in mode 1 gives popcnt = 2, index = 0, viol = 1.
- Back-to-back stream with first-violation capture:
  - Stimulus: 8 consecutive valid beats, with only beats 3 and 6 non-onehot (data 128'h3, then 128'hF0).
  - Response: viol_count = 2 and viol_sticky = 1 after beat 6; first_viol_data = 128'h3; out_valid contiguous for 8 cycles.
- Saturation:
  - Stimulus: CNT_W = 3, 10 violating beats.
  - Response: viol_count reads 1..7 and then holds at 7.
- clr interactions:
  - Stimulus: clr asserted on the same cycle a violating result registers.
  - Response: count, sticky and capture are 0 afterwards while out_viol = 1 that cycle.
  - Next violation: count = 1, and first_viol_data equals that new data.
- Async reset mid-stream:
  - Stimulus: drop rst_n between edges with 2 beats in flight.
  - Response: outputs go to 0 immediately; no out_valid appears for the dropped beats after release.
